// File: rtl/plot_framebuffer.sv
// 160x120x3 framebuffer behind the plot interface: two-stage write pipeline with
// collision detection, self-clearing control FSM and a valid/ready raster reader.
module plot_framebuffer #(
    parameter logic [2:0] PLAYER_COLOUR = 3'd4,
    parameter logic [2:0] OBS_COLOUR    = 3'd1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       plot,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       clear,
    input  logic       clear_collision,
    output logic       busy,
    output logic       collision,
    output logic       oob,
    input  logic       scan_start,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_x,
    output logic [6:0] out_y,
    output logic [2:0] out_colour,
    output logic       out_last
);

    localparam int unsigned FB_SIZE   = 19200;
    localparam logic [14:0] LAST_ADDR = 15'd19199;

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    function automatic logic [14:0] pix_addr(input logic [6:0] row, input logic [7:0] col);
        return {1'b0, row, 7'd0} + {3'd0, row, 5'd0} + {7'd0, col};
    endfunction

    function automatic logic pair_collides(input logic [2:0] old_c, input logic [2:0] new_c);
        return ((old_c == OBS_COLOUR) && (new_c == PLAYER_COLOUR)) ||
               ((old_c == PLAYER_COLOUR) && (new_c == OBS_COLOUR));
    endfunction

    logic [2:0]  mem_q [0:FB_SIZE-1];

    state_t      state_q, state_d;
    logic [14:0] clr_addr_q, clr_addr_d;
    logic        s2_valid_q;
    logic [14:0] s2_addr_q;
    logic [2:0]  s2_colour_q, s2_old_q;
    logic        collision_q, collision_d;
    logic        oob_q, oob_d;
    logic        scan_active_q, scan_active_d;
    logic [7:0]  rd_x_q, rd_x_d;
    logic [6:0]  rd_y_q, rd_y_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_x_q;
    logic [6:0]  out_y_q;
    logic [2:0]  out_colour_q;
    logic        out_last_q;

    logic        busy_s, in_range_s, s1_ok_s, oob_set_s, bypass_s, coll_set_s;
    logic        scan_idle_s, rd_en_s, rd_last_s;
    logic [14:0] wr_addr_s, rd_addr_s;

    assign busy_s      = (state_q == ST_CLEAR);
    assign in_range_s  = (x < 8'd160) && (y < 7'd120);
    assign s1_ok_s     = plot && in_range_s && !busy_s;
    assign oob_set_s   = plot && !in_range_s && !busy_s;
    assign wr_addr_s   = pix_addr(y, x);
    // S2 has not reached memory yet, so a same-address S1 must see S2's colour.
    assign bypass_s    = s2_valid_q && (s2_addr_q == wr_addr_s);
    assign coll_set_s  = s2_valid_q && pair_collides(s2_old_q, s2_colour_q);
    assign rd_addr_s   = pix_addr(rd_y_q, rd_x_q);
    assign rd_last_s   = (rd_x_q == 8'd159) && (rd_y_q == 7'd119);
    assign scan_idle_s = !scan_active_q && !out_valid_q;
    // No reads while clearing or on the clear request cycle, so no cleared data goes out valid.
    assign rd_en_s     = scan_active_q && (!out_valid_q || out_ready) && !busy_s && !clear;

    // Control FSM next state: sweep the clear address, restart on a clear request.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_CLEAR: begin
                if (clear) begin
                    clr_addr_d = 15'd0;
                end else if (clr_addr_q == LAST_ADDR) begin
                    state_d    = ST_RUN;
                    clr_addr_d = 15'd0;
                end else begin
                    clr_addr_d = clr_addr_q + 15'd1;
                end
            end
            ST_RUN: begin
                if (clear) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = 15'd0;
                end else begin
                    state_d    = ST_RUN;
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = 15'd0;
            end
        endcase
    end

    // Sticky flags; a new event wins over a same-cycle clear.
    always_comb begin
        collision_d = collision_q;
        oob_d       = oob_q;
        if (coll_set_s) begin
            collision_d = 1'b1;
        end else if (clear_collision) begin
            collision_d = 1'b0;
        end else begin
            collision_d = collision_q;
        end
        if (oob_set_s) begin
            oob_d = 1'b1;
        end else if (clear) begin
            oob_d = 1'b0;
        end else begin
            oob_d = oob_q;
        end
    end

    // Raster reader: start when idle, advance x fastest, retire after the last read.
    always_comb begin
        scan_active_d = scan_active_q;
        rd_x_d        = rd_x_q;
        rd_y_d        = rd_y_q;
        if (scan_idle_s && scan_start) begin
            scan_active_d = 1'b1;
            rd_x_d        = 8'd0;
            rd_y_d        = 7'd0;
        end else if (rd_en_s) begin
            if (rd_x_q == 8'd159) begin
                rd_x_d = 8'd0;
                if (rd_y_q == 7'd119) begin
                    rd_y_d        = 7'd0;
                    scan_active_d = 1'b0;
                end else begin
                    rd_y_d = rd_y_q + 7'd1;
                end
            end else begin
                rd_x_d = rd_x_q + 8'd1;
            end
        end else begin
            scan_active_d = scan_active_q;
        end
        out_valid_d = rd_en_s ? 1'b1 : (out_valid_q && !out_ready);
    end

    // State, pipeline and output registers, including the synchronous memory reads.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= ST_CLEAR;
            clr_addr_q    <= 15'd0;
            s2_valid_q    <= 1'b0;
            s2_addr_q     <= 15'd0;
            s2_colour_q   <= 3'd0;
            s2_old_q      <= 3'd0;
            collision_q   <= 1'b0;
            oob_q         <= 1'b0;
            scan_active_q <= 1'b0;
            rd_x_q        <= 8'd0;
            rd_y_q        <= 7'd0;
            out_valid_q   <= 1'b0;
            out_x_q       <= 8'd0;
            out_y_q       <= 7'd0;
            out_colour_q  <= 3'd0;
            out_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_addr_q    <= clr_addr_d;
            s2_valid_q    <= s1_ok_s;
            s2_addr_q     <= wr_addr_s;
            s2_colour_q   <= colour;
            collision_q   <= collision_d;
            oob_q         <= oob_d;
            scan_active_q <= scan_active_d;
            rd_x_q        <= rd_x_d;
            rd_y_q        <= rd_y_d;
            out_valid_q   <= out_valid_d;
            if (s1_ok_s) begin
                s2_old_q <= bypass_s ? s2_colour_q : mem_q[wr_addr_s];
            end
            if (rd_en_s) begin
                out_x_q      <= rd_x_q;
                out_y_q      <= rd_y_q;
                out_last_q   <= rd_last_s;
                out_colour_q <= mem_q[rd_addr_s];
            end
        end
    end

    // Memory write port; the clear sweep overrides a same-cycle S2 write.
    always_ff @(posedge clock) begin
        if (s2_valid_q) begin
            mem_q[s2_addr_q] <= s2_colour_q;
        end
        if (state_q == ST_CLEAR) begin
            mem_q[clr_addr_q] <= 3'd0;
        end
    end

    assign busy       = busy_s;
    assign collision  = collision_q;
    assign oob        = oob_q;
    assign out_valid  = out_valid_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_colour = out_colour_q;
    assign out_last   = out_last_q;

endmodule

// File: tb/tb_plot_framebuffer.sv
// Directed plus randomized bench for plot_framebuffer against a pixel-array reference model.
module tb_plot_framebuffer;

    localparam int PLAYER = 4;
    localparam int OBS    = 1;
    localparam int NPIX   = 19200;

    logic       clock = 1'b0;
    logic       resetn, plot, clear, clear_collision, scan_start, out_ready;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       busy, collision, oob, out_valid, out_last;
    logic [7:0] out_x;
    logic [6:0] out_y;
    logic [2:0] out_colour;

    int errors = 0;
    int checks = 0;
    int model [NPIX];
    bit model_coll = 1'b0;
    bit model_oob  = 1'b0;

    plot_framebuffer dut (
        .clock(clock), .resetn(resetn), .plot(plot), .x(x), .y(y), .colour(colour),
        .clear(clear), .clear_collision(clear_collision), .busy(busy),
        .collision(collision), .oob(oob), .scan_start(scan_start),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
        .out_colour(out_colour), .out_last(out_last)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: a write lands in order, collisions judged against the pixel it replaces.
    task automatic model_write(input int xx, input int yy, input int cc);
        int a;
        if (xx < 160 && yy < 120) begin
            a = yy * 160 + xx;
            if ((model[a] == OBS && cc == PLAYER) || (model[a] == PLAYER && cc == OBS))
                model_coll = 1'b1;
            model[a] = cc;
        end else begin
            model_oob = 1'b1;
        end
    endtask

    task automatic wr(input int xx, input int yy, input int cc);
        plot = 1'b1;
        x = xx[7:0];
        y = yy[6:0];
        colour = cc[2:0];
        model_write(xx, yy, cc);
        tick();
        plot = 1'b0;
    endtask

    // One full raster readout; optionally pulses clear (with a write burst) mid-scan.
    task automatic scan(input int pct, input int clear_after);
        int k = 0;
        int cyc = 0;
        int zero_from = NPIX;
        int busy_cnt = 0;
        int vbusy = 0;
        int burst_n = 0;
        int ex, ey, ec, el;
        bit restart_sent = 1'b0;
        bit prev_stall = 1'b0;
        int prev_vec = 0;
        int cur_vec;
        out_ready = 1'b0;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        check("scan_latency_1", int'(out_valid), 0);
        tick();
        check("scan_latency_2", int'(out_valid), 1);
        while (k < NPIX && cyc < 50000) begin
            out_ready = ($urandom_range(99) < pct);
            plot = 1'b0;
            clear = 1'b0;
            scan_start = 1'b0;
            if (clear_after >= 0 && k >= clear_after - 3 && burst_n < 7) begin
                plot = 1'b1;
                x = 8'(burst_n * 5);
                y = 7'd100;
                colour = 3'd2;
                if (burst_n == 3) begin
                    clear = 1'b1;
                    zero_from = k + int'(out_valid);
                    if (pct == 100) check("full_rate", cyc, k);
                end
                burst_n++;
            end
            if (k == 500 && !restart_sent) begin
                scan_start = 1'b1;
                restart_sent = 1'b1;
            end
            if (busy) begin
                busy_cnt++;
                if (out_valid) vbusy++;
            end
            cur_vec = int'({out_valid, out_x, out_y, out_colour, out_last});
            if (prev_stall) check("stall_hold", cur_vec, prev_vec);
            if (out_valid && out_ready) begin
                ex = k % 160;
                ey = k / 160;
                ec = (k < zero_from) ? model[k] : 0;
                el = (k == NPIX - 1) ? 1 : 0;
                check("pixel", int'({out_x, out_y, out_colour, out_last}),
                      (ex << 11) | (ey << 4) | (ec << 1) | el);
                k++;
            end
            prev_stall = out_valid && !out_ready;
            prev_vec = cur_vec;
            tick();
            cyc++;
        end
        plot = 1'b0;
        clear = 1'b0;
        scan_start = 1'b0;
        out_ready = 1'b0;
        check("scan_transfers", k, NPIX);
        check("scan_done_valid", int'(out_valid), 0);
        if (clear_after >= 0) begin
            check("clear_busy_cycles", busy_cnt, NPIX);
            check("valid_during_clear", vbusy, 0);
            for (int i = 0; i < NPIX; i++) model[i] = 0;
        end
    endtask

    initial begin
        int n;
        int xx, yy, cc;
        for (int i = 0; i < NPIX; i++) model[i] = 0;
        resetn = 1'b0; plot = 1'b0; clear = 1'b0; clear_collision = 1'b0;
        scan_start = 1'b0; out_ready = 1'b0; x = 8'd0; y = 7'd0; colour = 3'd0;
        tick(); tick(); tick();
        check("rst_busy", int'(busy), 1);
        check("rst_collision", int'(collision), 0);
        check("rst_oob", int'(oob), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_xyc", int'({out_x, out_y, out_colour}), 0);

        resetn = 1'b1;
        n = 0;
        while (busy && n < 20000) begin
            tick();
            n++;
        end
        check("initial_clear_len", n, NPIX);

        // Accepted on the very cycle busy falls.
        wr(0, 0, 2);

        // Back-to-back same-address writes exercise the bypass.
        wr(10, 5, OBS);
        wr(10, 5, PLAYER);
        check("bypass_coll_early", int'(collision), 0);
        tick();
        check("bypass_coll_set", int'(collision), 1);

        clear_collision = 1'b1;
        tick();
        clear_collision = 1'b0;
        model_coll = 1'b0;
        check("coll_cleared", int'(collision), 0);

        check("oob_before", int'(oob), 0);
        wr(160, 0, 3);
        wr(0, 120, 3);
        tick();
        check("oob_set", int'(oob), 1);
        check("oob_no_coll", int'(collision), 0);

        // Set and clear_collision on the same cycle: set wins.
        wr(3, 3, OBS);
        tick(); tick();
        check("coll_plain_write", int'(collision), 0);
        wr(3, 3, PLAYER);
        clear_collision = 1'b1;
        tick();
        clear_collision = 1'b0;
        check("coll_set_wins", int'(collision), 1);
        clear_collision = 1'b1;
        tick();
        clear_collision = 1'b0;
        model_coll = 1'b0;
        check("coll_clear_alone", int'(collision), 0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(3) != 0) begin
                xx = $urandom_range(16, 1);
                yy = $urandom_range(7, 0);
                cc = ($urandom_range(1) == 1) ? PLAYER : OBS;
                if ($urandom_range(4) == 0) cc = $urandom_range(7);
            end else begin
                xx = $urandom_range(150, 20);
                yy = $urandom_range(119, 0);
                cc = $urandom_range(7);
            end
            if ($urandom_range(19) == 0) xx = 160 + $urandom_range(10);
            wr(xx, yy, cc);
        end
        wr(159, 119, 7);
        tick(); tick();
        check("rand_collision", int'(collision), int'(model_coll));
        check("rand_oob", int'(oob), int'(model_oob));

        scan(80, -1);
        scan(100, 300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/plot_framebuffer.md
# plot_framebuffer

Pixel sink at the far end of the plot interface driven by the object datapaths (`x`, `y`, `colour`, `plot`). Stores every accepted write in a 160x120, 3-bit framebuffer, flags player/obstacle collisions by comparing each write with the pixel it overwrites, and streams the framebuffer out in raster order over a valid/ready handshake for the display side. It also owns framebuffer clearing after reset and on request.

## Interface
- `PLAYER_COLOUR`, default 3'd4: colour code that marks player pixels.
- `OBS_COLOUR`, default 3'd1: colour code that marks obstacle pixels.
- `clock` input 1: single clock; all logic on its rising edge.
- `resetn` input 1: reset, synchronous, active-low.
- `plot` input 1: write strobe; one pixel write per cycle while high.
- `x` input 8: write column, valid 0..159.
- `y` input 7: write row, valid 0..119.
- `colour` input 3: write colour.
- `clear` input 1: single-cycle pulse that starts a full-framebuffer clear.
- `clear_collision` input 1: clears the sticky `collision` flag.
- `busy` output 1: high while clearing; writes are dropped.
- `collision` output 1: sticky collision flag.
- `oob` output 1: sticky flag; an out-of-range write was seen. Cleared by `clear`.
- `scan_start` input 1: pulse that starts one raster readout.
- `out_valid` output 1: stream pixel valid.
- `out_ready` input 1: display side accepts the pixel.
- `out_x` output 8, `out_y` output 7, `out_colour` output 3: the streamed pixel.
- `out_last` output 1: high with pixel (159,119).

## Operation
- Memory: 19200 x 3 bits. Address = y*160 + x, 15 bits, computed as {y,7'b0}+{y,5'b0}+x.
- Control FSM has two states, CLEAR and RUN.
  - Reset enters CLEAR with the clear address at 0. `clear` in RUN also enters CLEAR.
  - CLEAR writes 3'd0 to one address per cycle, from 0 to 19199, then goes to RUN. `busy` = (state == CLEAR).
  - `clear` while already in CLEAR restarts the clear address at 0.
- Write pipeline, used in RUN only:
  - S1: qualify the write (`plot` && x<160 && y<120 && !busy) and read the old pixel.
  - S2: write the new colour and compare it with the old one.
  - A write with x>=160 or y>=120 is dropped and sets `oob`.
  - `plot` while busy is dropped silently.
- Bypass: if S2 holds a write to the same address as S1, S1 takes S2's colour as the old value. Back-to-back writes to one address must behave sequentially.
- Collision: in S2, set `collision` if the pair (old, new) is either (OBS_COLOUR, PLAYER_COLOUR) or (PLAYER_COLOUR, OBS_COLOUR).
  - `collision` stays set until `clear_collision`.
  - If a set and `clear_collision` coincide, the set wins.
- Raster reader: `scan_start` while idle starts a scan over y=0..119, x=0..159 (x fastest), one synchronous read per pixel.
  - `scan_start` during an active scan is ignored.
  - The scan pauses while `busy` and resumes afterwards. The stream must never output clear-in-progress data as valid.
- Stream handshake:
  - A pixel transfers when `out_valid && out_ready`.
  - While `out_valid && !out_ready`, all of `out_x`, `out_y`, `out_colour` and `out_last` hold stable.
  - `out_valid` never drops without a transfer.
  - The scan ends after the transfer with `out_last`=1.
- Reader/writer ordering: the reader returns the memory contents at its read cycle. No further ordering is guaranteed against writes in flight.

## Timing
- Reset values: `busy`=1, `collision`=0, `oob`=0, `out_valid`=0, `out_last`=0, `out_x`=0, `out_y`=0, `out_colour`=0, scan idle.
- Reset mid-scan or mid-clear aborts the operation and restarts the clear.
- Clear takes 19200 cycles. `busy` falls on the cycle after address 19199 is written. `plot` is accepted on that same cycle.
- Write latency: a `plot` at cycle N is in memory from N+2. `collision` rises at N+2.
- Throughput is one write per cycle, with no stalls in RUN.
- Stream: the first `out_valid` appears 2 cycles after `scan_start`.
- With `out_ready` held high, the stream sustains one pixel per cycle. A full frame takes 19200 transfers.
- `clear` in RUN: `busy` rises on the next cycle. Writes already in S1/S2 complete before clearing begins at address 0.

## Test plan
- Reset, then 19200 idle cycles → `busy` falls on exactly cycle 19200. A scan returns all 19200 pixels with colour 0, `out_last` only on (159,119).
- Write (10,5) colour 1, then (10,5) colour 4 on consecutive cycles → `collision`=1 two cycles after the second write (bypass path). A scan shows (10,5)=4.
- Write (160,0) and (0,120) → `oob`=1, `collision` stays 0, and a scan confirms memory is unchanged.
- Write (3,3) colour 4 and hold `clear_collision`=1 on the cycle `collision` would set → `collision`=1. Pulse `clear_collision` alone → 0.
- Scan with `out_ready` toggling pseudo-randomly → exactly 19200 transfers in raster order, outputs stable during stalls, with writes (0,0)=2 and (159,119)=7 visible.
- Pulse `clear` during a scan and during a write burst → `busy` high for 19200 cycles, the scan pauses with no valid pixels, and all later reads return 0.
